// File: rtl/ram_sdp_sync_read_be_if.sv
// Bus bundle for ram_sdp_sync_read_be: write port, read port and clear-engine handshake.
// The master drives requests; the slave (the RAM) returns read data, valid and busy.
interface ram_sdp_sync_read_be_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                    clr_req;
    logic                    busy;
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [DATA_WIDTH/8-1:0] wr_be;
    logic                    rd_en;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    rd_valid;

    modport master (
        output clr_req, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        input  busy, rd_data, rd_valid
    );

    modport slave (
        input  clr_req, wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        output busy, rd_data, rd_valid
    );
endinterface

// File: rtl/ram_sdp_sync_read_be.sv
// Simple-dual-port RAM with byte-lane writes, a synchronous read port, a selectable
// read-during-write mode, an optional output register and a hardware clear engine.
module ram_sdp_sync_read_be #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DEPTH      = 16,
    parameter int OUT_REG    = 0,
    parameter int RDW_MODE   = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ram_sdp_sync_read_be_if.slave  bus
);
    localparam int NB = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  rd1_valid_q, rd1_valid_d;
    logic [DATA_WIDTH-1:0] rd1_data_q, rd1_data_d;
    logic                  rd2_valid_q, rd2_valid_d;
    logic [DATA_WIDTH-1:0] rd2_data_q, rd2_data_d;

    logic                  idle;
    logic                  wr_in_range;
    logic                  rd_in_range;
    logic                  rd_accept;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [NB-1:0]         mem_wbe;
    logic [DATA_WIDTH-1:0] rd_word;

    assign idle        = (state_q == ST_IDLE);
    assign wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_W);
    assign rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_W);
    assign rd_accept   = bus.rd_en && idle;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.clr_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // The clear engine owns the single write port while it runs; user writes are dropped.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = bus.wr_addr;
        mem_wdata = bus.wr_data;
        mem_wbe   = bus.wr_be;
        if (!idle) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = '0;
            mem_wbe   = '1;
        end else if (bus.wr_en && wr_in_range) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_wbe[i]) begin
                    mem[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // Write-first forwarding merges only the enabled lanes over the old word.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[bus.rd_addr];
        end
        if ((RDW_MODE != 0) && mem_we && rd_in_range && (mem_waddr == bus.rd_addr)) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_wbe[i]) begin
                    rd_word[8*i +: 8] = mem_wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        rd1_valid_d = rd_accept;
        rd1_data_d  = rd_accept ? rd_word : rd1_data_q;
        rd2_valid_d = rd1_valid_q;
        rd2_data_d  = rd1_valid_q ? rd1_data_q : rd2_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rd1_valid_q <= 1'b0;
            rd1_data_q  <= '0;
            rd2_valid_q <= 1'b0;
            rd2_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd1_valid_q <= rd1_valid_d;
            rd1_data_q  <= rd1_data_d;
            rd2_valid_q <= rd2_valid_d;
            rd2_data_q  <= rd2_data_d;
        end
    end

    assign bus.busy     = !idle;
    assign bus.rd_valid = (OUT_REG != 0) ? rd2_valid_q : rd1_valid_q;
    assign bus.rd_data  = (OUT_REG != 0) ? rd2_data_q  : rd1_data_q;

endmodule

// File: tb/tb_ram_sdp_sync_read_be.sv
// Directed bench for ram_sdp_sync_read_be: three configurations (8-bit read-first,
// 32-bit write-first, 16-bit pipelined DEPTH=12) exercised with hand-computed vectors.
module tb_ram_sdp_sync_read_be;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    ram_sdp_sync_read_be_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(4)) ifa ();
    ram_sdp_sync_read_be_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) ifb ();
    ram_sdp_sync_read_be_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) ifc ();

    ram_sdp_sync_read_be dut_a (.clk(clk), .rst_n(rst_a), .bus(ifa));

    ram_sdp_sync_read_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .DEPTH(16), .OUT_REG(0), .RDW_MODE(1))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    ram_sdp_sync_read_be #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .DEPTH(12), .OUT_REG(1), .RDW_MODE(0))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    typedef struct {
        logic       we;
        logic [3:0] wa;
        logic [7:0] wd;
        logic [0:0] be;
        logic       re;
        logic [3:0] ra;
        logic       ev;
        logic [7:0] ed;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        ifa.wr_en   = v.we;
        ifa.wr_addr = v.wa;
        ifa.wr_data = v.wd;
        ifa.wr_be   = v.be;
        ifa.rd_en   = v.re;
        ifa.rd_addr = v.ra;
        @(posedge clk);
        #1;
        checkOutput($sformatf("a_vec%0d_valid", idx), 32'(ifa.rd_valid), 32'(v.ev));
        checkOutput($sformatf("a_vec%0d_data", idx), 32'(ifa.rd_data), 32'(v.ed));
    endtask

    task automatic cycleA(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                          input logic re, input logic [3:0] ra);
        ifa.wr_en   = we;
        ifa.wr_addr = wa;
        ifa.wr_data = wd;
        ifa.wr_be   = 1'b1;
        ifa.rd_en   = re;
        ifa.rd_addr = ra;
        @(posedge clk);
        #1;
    endtask

    task automatic cycleB(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                          input logic [3:0] be, input logic re, input logic [3:0] ra);
        ifb.wr_en   = we;
        ifb.wr_addr = wa;
        ifb.wr_data = wd;
        ifb.wr_be   = be;
        ifb.rd_en   = re;
        ifb.rd_addr = ra;
        @(posedge clk);
        #1;
    endtask

    task automatic cycleC(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                          input logic [1:0] be, input logic re, input logic [3:0] ra);
        ifc.wr_en   = we;
        ifc.wr_addr = wa;
        ifc.wr_data = wd;
        ifc.wr_be   = be;
        ifc.rd_en   = re;
        ifc.rd_addr = ra;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t       vecs [11];
        logic [3:0] pipe_ra [6];
        logic       pipe_re [6];
        logic       pipe_ev [6];
        logic [15:0] pipe_ed [6];
        int         busy_cycles;
        logic       saw_valid;

        vecs[0]  = '{1'b1, 4'd3,  8'hA5, 1'b1, 1'b0, 4'd0,  1'b0, 8'h00};
        vecs[1]  = '{1'b1, 4'd15, 8'h3C, 1'b1, 1'b0, 4'd0,  1'b0, 8'h00};
        vecs[2]  = '{1'b0, 4'd0,  8'h00, 1'b0, 1'b1, 4'd3,  1'b1, 8'hA5};
        vecs[3]  = '{1'b0, 4'd0,  8'h00, 1'b0, 1'b1, 4'd15, 1'b1, 8'h3C};
        vecs[4]  = '{1'b0, 4'd0,  8'h00, 1'b0, 1'b0, 4'd0,  1'b0, 8'h3C};
        vecs[5]  = '{1'b1, 4'd7,  8'h5A, 1'b1, 1'b1, 4'd3,  1'b1, 8'hA5};
        vecs[6]  = '{1'b1, 4'd3,  8'h11, 1'b1, 1'b1, 4'd3,  1'b1, 8'hA5};
        vecs[7]  = '{1'b1, 4'd7,  8'h00, 1'b0, 1'b1, 4'd3,  1'b1, 8'h11};
        vecs[8]  = '{1'b0, 4'd0,  8'h00, 1'b0, 1'b1, 4'd7,  1'b1, 8'h5A};
        vecs[9]  = '{1'b1, 4'd3,  8'h99, 1'b1, 1'b1, 4'd15, 1'b1, 8'h3C};
        vecs[10] = '{1'b0, 4'd0,  8'h00, 1'b0, 1'b1, 4'd3,  1'b1, 8'h99};

        pipe_re = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        pipe_ra = '{4'd0, 4'd1, 4'd11, 4'd13, 4'd0, 4'd0};
        pipe_ev = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        pipe_ed = '{16'h0000, 16'h1111, 16'h2222, 16'hBBBB, 16'h0000, 16'h0000};

        {ifa.clr_req, ifa.wr_en, ifa.wr_addr, ifa.wr_data, ifa.wr_be, ifa.rd_en, ifa.rd_addr} = '0;
        {ifb.clr_req, ifb.wr_en, ifb.wr_addr, ifb.wr_data, ifb.wr_be, ifb.rd_en, ifb.rd_addr} = '0;
        {ifc.clr_req, ifc.wr_en, ifc.wr_addr, ifc.wr_data, ifc.wr_be, ifc.rd_en, ifc.rd_addr} = '0;

        // Outputs must sit at zero while reset is held across clock edges.
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("rst_a_data",  32'(ifa.rd_data),  32'h0);
        checkOutput("rst_a_valid", 32'(ifa.rd_valid), 32'h0);
        checkOutput("rst_a_busy",  32'(ifa.busy),     32'h0);
        checkOutput("rst_b_data",  32'(ifb.rd_data),  32'h0);
        checkOutput("rst_b_valid", 32'(ifb.rd_valid), 32'h0);
        checkOutput("rst_c_data",  32'(ifc.rd_data),  32'h0);
        checkOutput("rst_c_valid", 32'(ifc.rd_valid), 32'h0);
        checkOutput("rst_c_busy",  32'(ifc.busy),     32'h0);
        rst_a = 1'b1;
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i], i);
        end
        cycleA(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);

        // 32-bit write-first: byte-lane merge and same-address forwarding.
        cycleB(1'b1, 4'd2, 32'h11223344, 4'hF,    1'b0, 4'd0);
        cycleB(1'b1, 4'd2, 32'hAABBCCDD, 4'b0101, 1'b0, 4'd0);
        cycleB(1'b0, 4'd0, 32'h0,        4'h0,    1'b1, 4'd2);
        checkOutput("b_be_valid", 32'(ifb.rd_valid), 32'h1);
        checkOutput("b_be_data",  ifb.rd_data,       32'h11BB33DD);
        cycleB(1'b1, 4'd5, 32'h12345678, 4'hF,    1'b0, 4'd0);
        cycleB(1'b1, 4'd5, 32'hABCDEF01, 4'b0011, 1'b1, 4'd5);
        checkOutput("b_wf_coll_valid", 32'(ifb.rd_valid), 32'h1);
        checkOutput("b_wf_coll_data",  ifb.rd_data,       32'h1234EF01);
        cycleB(1'b0, 4'd0, 32'h0,        4'h0,    1'b1, 4'd5);
        checkOutput("b_wf_after_data", ifb.rd_data, 32'h1234EF01);
        cycleB(1'b0, 4'd0, 32'h0,        4'h0,    1'b0, 4'd0);
        checkOutput("b_idle_valid", 32'(ifb.rd_valid), 32'h0);

        // 16-bit DEPTH=12 with output register: two-cycle latency and range handling.
        cycleC(1'b1, 4'd0,  16'h1111, 2'b11, 1'b0, 4'd0);
        cycleC(1'b1, 4'd1,  16'h2222, 2'b11, 1'b0, 4'd0);
        cycleC(1'b1, 4'd11, 16'hBBBB, 2'b11, 1'b0, 4'd0);
        cycleC(1'b1, 4'd5,  16'h1234, 2'b11, 1'b0, 4'd0);
        cycleC(1'b1, 4'd13, 16'hDDDD, 2'b11, 1'b0, 4'd0);
        for (int i = 0; i < 6; i++) begin
            cycleC(1'b0, 4'd0, 16'h0, 2'b00, pipe_re[i], pipe_ra[i]);
            checkOutput($sformatf("c_pipe%0d_valid", i), 32'(ifc.rd_valid), 32'(pipe_ev[i]));
            checkOutput($sformatf("c_pipe%0d_data", i),  32'(ifc.rd_data),  32'(pipe_ed[i]));
        end
        cycleC(1'b1, 4'd5, 16'hABCD, 2'b01, 1'b1, 4'd5);
        checkOutput("c_rf_lat_valid", 32'(ifc.rd_valid), 32'h0);
        cycleC(1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0);
        checkOutput("c_rf_coll_valid", 32'(ifc.rd_valid), 32'h1);
        checkOutput("c_rf_coll_data",  32'(ifc.rd_data),  32'h1234);
        cycleC(1'b0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd5);
        cycleC(1'b0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0);
        checkOutput("c_rf_after_valid", 32'(ifc.rd_valid), 32'h1);
        checkOutput("c_rf_after_data",  32'(ifc.rd_data),  32'h12CD);

        // Clear engine: fill, clear, and poke the ports while busy.
        for (int i = 0; i < 16; i++) cycleA(1'b1, 4'(i), 8'hFF, 1'b0, 4'd0);
        ifa.clr_req = 1'b1;
        cycleA(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
        ifa.clr_req = 1'b0;
        busy_cycles = 0;
        saw_valid   = 1'b0;
        while (ifa.busy && busy_cycles < 40) begin
            busy_cycles++;
            ifa.clr_req = (busy_cycles == 5);
            cycleA(1'b1, 4'd1, 8'h77, 1'b1, 4'd2);
            if (ifa.rd_valid) saw_valid = 1'b1;
        end
        ifa.clr_req = 1'b0;
        cycleA(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
        checkOutput("clr_busy_cycles", 32'(busy_cycles), 32'd16);
        checkOutput("clr_no_valid",    32'(saw_valid),   32'h0);
        for (int i = 0; i < 16; i++) begin
            cycleA(1'b0, 4'd0, 8'h00, 1'b1, 4'(i));
            checkOutput($sformatf("clr_rd%0d", i), {23'h0, ifa.rd_valid, ifa.rd_data}, {23'h0, 1'b1, 8'h00});
        end

        // Reset while the clear counter sits at 6: addresses 0-5 cleared, 6-15 untouched.
        for (int i = 0; i < 16; i++) cycleA(1'b1, 4'(i), 8'hFF, 1'b0, 4'd0);
        ifa.clr_req = 1'b1;
        cycleA(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
        ifa.clr_req = 1'b0;
        for (int i = 0; i < 6; i++) cycleA(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
        checkOutput("mid_busy_before", 32'(ifa.busy), 32'h1);
        rst_a = 1'b0;
        #1;
        checkOutput("mid_busy_rst",  32'(ifa.busy),    32'h0);
        checkOutput("mid_data_rst",  32'(ifa.rd_data), 32'h0);
        #2;
        rst_a = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cycleA(1'b0, 4'd0, 8'h00, 1'b1, 4'(i));
            checkOutput($sformatf("mid_rd%0d", i), {23'h0, ifa.rd_valid, ifa.rd_data},
                        {23'h0, 1'b1, (i < 6) ? 8'h00 : 8'hFF});
        end
        cycleA(1'b0, 4'd0, 8'h00, 1'b0, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
